// File: rtl/blockram_pkg.sv
// Shared definitions for the initialised dual-port block RAM: clear-FSM encoding,
// lane-count helper and parameter sanity checks.
package blockram_pkg;

  localparam int unsigned BRAM_STATE_W = 1;

  localparam logic [BRAM_STATE_W-1:0] BRAM_STATE_IDLE = 1'b0;
  localparam logic [BRAM_STATE_W-1:0] BRAM_STATE_INIT = 1'b1;

  function automatic int unsigned byte_en_width(input int unsigned element_bits);
    return element_bits / 8;
  endfunction

  function automatic bit element_width_ok(input int unsigned element_bits);
    return (element_bits > 0) && ((element_bits % 8) == 0);
  endfunction

  function automatic bit depth_ok(input int unsigned number_sets);
    return number_sets >= 2;
  endfunction

endpackage

// File: rtl/blockram_byte_merge.sv
// Overlays the byte lanes of a colliding write onto the data read from the array,
// so a same-address read returns the freshly written bytes.
module blockram_byte_merge #(
  parameter int unsigned BYTE_EN_WIDTH = 8
) (
  input  logic                       merge_en,
  input  logic [BYTE_EN_WIDTH-1:0]   byte_en,
  input  logic [8*BYTE_EN_WIDTH-1:0] write_data,
  input  logic [8*BYTE_EN_WIDTH-1:0] array_data,
  output logic [8*BYTE_EN_WIDTH-1:0] merged_c
);

  always_comb begin
    merged_c = array_data;
    for (int i = 0; i < int'(BYTE_EN_WIDTH); i++) begin
      if (merge_en && byte_en[i]) begin
        merged_c[8*i +: 8] = write_data[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/dual_port_blockram_init.sv
// Simple-dual-port block RAM with byte enables, selectable collision policy,
// optional output register and a post-reset clear engine.
module dual_port_blockram_init
  import blockram_pkg::*;
#(
  parameter int unsigned SINGLE_ELEMENT_SIZE_IN_BITS = 64,
  parameter int unsigned NUMBER_SETS                 = 64,
  parameter int unsigned SET_PTR_WIDTH_IN_BITS       = $clog2(NUMBER_SETS),
  parameter int unsigned BYTE_EN_WIDTH               = byte_en_width(SINGLE_ELEMENT_SIZE_IN_BITS),
  parameter int unsigned OUTPUT_REG                  = 0,
  parameter int unsigned WRITE_FIRST                 = 1,
  parameter logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] INIT_VALUE = '0
) (
  input  logic                                   clk_in,
  input  logic                                   reset_in,
  input  logic                                   read_en_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]       read_set_addr_in,
  output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] read_element_out,
  output logic                                   read_valid_out,
  input  logic                                   write_en_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]       write_set_addr_in,
  input  logic [BYTE_EN_WIDTH-1:0]               write_byte_en_in,
  input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] write_element_in,
  output logic                                   init_busy_out
);

  localparam int unsigned DW = SINGLE_ELEMENT_SIZE_IN_BITS;
  localparam int unsigned AW = SET_PTR_WIDTH_IN_BITS;
  localparam int unsigned BW = BYTE_EN_WIDTH;
  localparam logic [AW-1:0] LAST_SET = AW'(NUMBER_SETS - 1);

  if (!element_width_ok(SINGLE_ELEMENT_SIZE_IN_BITS)) begin : g_bad_width
    $error("SINGLE_ELEMENT_SIZE_IN_BITS must be a non-zero multiple of 8");
  end
  if (!depth_ok(NUMBER_SETS)) begin : g_bad_depth
    $error("NUMBER_SETS must be at least 2");
  end

  logic [BRAM_STATE_W-1:0] state_q, state_d;
  logic [AW-1:0]           count_q, count_d;
  logic                    busy_q;
  logic                    valid1_q;

  logic                    mem_we;
  logic [AW-1:0]           mem_addr;
  logic [BW-1:0]           mem_be;
  logic [DW-1:0]           mem_wdata;

  logic                    read_acc;
  logic                    write_acc;

  (* ram_style = "block" *) logic [DW-1:0] mem [NUMBER_SETS];
  logic [DW-1:0]           rd_data_q;
  logic [DW-1:0]           stage1_data;

  // Requests are only honoured in normal operation and never on a reset cycle.
  assign read_acc  = read_en_in  && (state_q == BRAM_STATE_IDLE) && !reset_in;
  assign write_acc = write_en_in && (state_q == BRAM_STATE_IDLE) && !reset_in;

  // Clear FSM next-state and array write-port selection.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    mem_we    = 1'b0;
    mem_addr  = write_set_addr_in;
    mem_be    = write_byte_en_in;
    mem_wdata = write_element_in;
    case (state_q)
      BRAM_STATE_INIT: begin
        mem_we    = !reset_in;
        mem_addr  = count_q;
        mem_be    = '1;
        mem_wdata = INIT_VALUE;
        count_d   = AW'(count_q + 1'b1);
        if (count_q == LAST_SET) begin
          state_d = BRAM_STATE_IDLE;
        end
      end
      default: begin
        mem_we = write_acc;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q  <= BRAM_STATE_INIT;
      count_q  <= '0;
      busy_q   <= 1'b1;
      valid1_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      busy_q   <= (state_d == BRAM_STATE_INIT);
      valid1_q <= read_acc;
    end
  end

  assign init_busy_out = busy_q;

  // Array: byte-lane writes and an unconditional registered read (old data on collision).
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < int'(BW); i++) begin
      if (mem_we && mem_be[i]) begin
        mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
    rd_data_q <= mem[read_set_addr_in];
  end

  if (WRITE_FIRST != 0) begin : g_write_first
    logic          coll_q;
    logic [DW-1:0] wr_data_q;
    logic [BW-1:0] wr_be_q;

    always_ff @(posedge clk_in) begin
      if (reset_in) begin
        coll_q <= 1'b0;
      end else begin
        coll_q <= read_acc && write_acc && (read_set_addr_in == write_set_addr_in);
      end
    end

    always_ff @(posedge clk_in) begin
      wr_data_q <= write_element_in;
      wr_be_q   <= write_byte_en_in;
    end

    blockram_byte_merge #(
      .BYTE_EN_WIDTH (BW)
    ) u_byte_merge (
      .merge_en   (coll_q),
      .byte_en    (wr_be_q),
      .write_data (wr_data_q),
      .array_data (rd_data_q),
      .merged_c   (stage1_data)
    );
  end else begin : g_read_first
    assign stage1_data = rd_data_q;
  end

  if (OUTPUT_REG != 0) begin : g_out_reg
    logic [DW-1:0] out_q;
    logic          valid2_q;

    always_ff @(posedge clk_in) begin
      if (reset_in) begin
        out_q    <= '0;
        valid2_q <= 1'b0;
      end else begin
        valid2_q <= valid1_q;
        if (valid1_q) begin
          out_q <= stage1_data;
        end
      end
    end

    assign read_element_out = out_q;
    assign read_valid_out   = valid2_q;
  end else begin : g_out_direct
    logic [DW-1:0] hold_q;

    // Remembers the last completed read so the output holds between reads.
    always_ff @(posedge clk_in) begin
      if (reset_in) begin
        hold_q <= '0;
      end else if (valid1_q) begin
        hold_q <= stage1_data;
      end
    end

    assign read_element_out = valid1_q ? stage1_data : hold_q;
    assign read_valid_out   = valid1_q;
  end

endmodule

// File: tb/tb_dual_port_blockram_init.sv
// Directed bench for dual_port_blockram_init: write-first, read-first and
// output-register variants driven from one shared stimulus.
module tb_dual_port_blockram_init;

  localparam logic [63:0] IV = 64'hDEAD_BEEF_0000_0001;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        read_en_in;
  logic [5:0]  read_set_addr_in;
  logic        write_en_in;
  logic [5:0]  write_set_addr_in;
  logic [7:0]  write_byte_en_in;
  logic [63:0] write_element_in;

  logic [63:0] wf_data, rf_data, or_data;
  logic        wf_valid, rf_valid, or_valid;
  logic        wf_busy, rf_busy, or_busy;

  int total = 0;
  int bad   = 0;

  always #5 clk_in = ~clk_in;

  dual_port_blockram_init #(.INIT_VALUE(IV), .WRITE_FIRST(1), .OUTPUT_REG(0)) dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .read_en_in(read_en_in), .read_set_addr_in(read_set_addr_in),
    .read_element_out(wf_data), .read_valid_out(wf_valid),
    .write_en_in(write_en_in), .write_set_addr_in(write_set_addr_in),
    .write_byte_en_in(write_byte_en_in), .write_element_in(write_element_in),
    .init_busy_out(wf_busy));

  dual_port_blockram_init #(.INIT_VALUE(IV), .WRITE_FIRST(0), .OUTPUT_REG(0)) dut_rf (
    .clk_in(clk_in), .reset_in(reset_in),
    .read_en_in(read_en_in), .read_set_addr_in(read_set_addr_in),
    .read_element_out(rf_data), .read_valid_out(rf_valid),
    .write_en_in(write_en_in), .write_set_addr_in(write_set_addr_in),
    .write_byte_en_in(write_byte_en_in), .write_element_in(write_element_in),
    .init_busy_out(rf_busy));

  dual_port_blockram_init #(.INIT_VALUE(IV), .WRITE_FIRST(1), .OUTPUT_REG(1)) dut_or (
    .clk_in(clk_in), .reset_in(reset_in),
    .read_en_in(read_en_in), .read_set_addr_in(read_set_addr_in),
    .read_element_out(or_data), .read_valid_out(or_valid),
    .write_en_in(write_en_in), .write_set_addr_in(write_set_addr_in),
    .write_byte_en_in(write_byte_en_in), .write_element_in(write_element_in),
    .init_busy_out(or_busy));

  typedef struct packed {
    logic        rd_en;
    logic [5:0]  rd_addr;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [7:0]  be;
    logic [63:0] wdata;
    logic        exp_valid;
    logic [63:0] exp_wf;
    logic [63:0] exp_rf;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic rd_en, input logic [5:0] rd_addr,
                              input logic wr_en, input logic [5:0] wr_addr,
                              input logic [7:0] be, input logic [63:0] wdata,
                              input logic exp_valid, input logic [63:0] exp_wf,
                              input logic [63:0] exp_rf);
    vec_t v;
    v.rd_en = rd_en; v.rd_addr = rd_addr; v.wr_en = wr_en; v.wr_addr = wr_addr;
    v.be = be; v.wdata = wdata; v.exp_valid = exp_valid;
    v.exp_wf = exp_wf; v.exp_rf = exp_rf;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rd_en, input logic [5:0] rd_addr,
                       input logic wr_en, input logic [5:0] wr_addr,
                       input logic [7:0] be, input logic [63:0] wdata);
    read_en_in        = rd_en;
    read_set_addr_in  = rd_addr;
    write_en_in       = wr_en;
    write_set_addr_in = wr_addr;
    write_byte_en_in  = be;
    write_element_in  = wdata;
  endtask

  initial begin
    int   n;
    logic prev_valid;
    logic [63:0] prev_data;

    reset_in = 1'b1;
    drive(1'b0, 6'd0, 1'b0, 6'd0, 8'h00, 64'h0);

    vecs[0]  = mk(1, 6'd0,  0, 6'd0,  8'h00, 64'h0, 1, IV, IV);
    vecs[1]  = mk(1, 6'd31, 0, 6'd0,  8'h00, 64'h0, 1, IV, IV);
    vecs[2]  = mk(1, 6'd63, 0, 6'd0,  8'h00, 64'h0, 1, IV, IV);
    vecs[3]  = mk(0, 6'd0,  1, 6'd5,  8'hFF, 64'h1122334455667788, 0, IV, IV);
    vecs[4]  = mk(0, 6'd0,  1, 6'd5,  8'h0F, 64'hAAAAAAAABBBBBBBB, 0, IV, IV);
    vecs[5]  = mk(1, 6'd5,  0, 6'd0,  8'h00, 64'h0, 1, 64'h11223344BBBBBBBB, 64'h11223344BBBBBBBB);
    vecs[6]  = mk(0, 6'd0,  0, 6'd0,  8'h00, 64'h0, 0, 64'h11223344BBBBBBBB, 64'h11223344BBBBBBBB);
    vecs[7]  = mk(0, 6'd0,  1, 6'd9,  8'hFF, 64'h0, 0, 64'h11223344BBBBBBBB, 64'h11223344BBBBBBBB);
    vecs[8]  = mk(1, 6'd9,  1, 6'd9,  8'h03, 64'hFFFFFFFFFFFFFFFF, 1, 64'h000000000000FFFF, 64'h0);
    vecs[9]  = mk(1, 6'd9,  0, 6'd0,  8'h00, 64'h0, 1, 64'h000000000000FFFF, 64'h000000000000FFFF);
    vecs[10] = mk(1, 6'd10, 1, 6'd10, 8'h81, 64'h0102030405060708, 1, 64'h01ADBEEF00000008, IV);
    vecs[11] = mk(1, 6'd10, 0, 6'd0,  8'h00, 64'h0, 1, 64'h01ADBEEF00000008, 64'h01ADBEEF00000008);
    vecs[12] = mk(1, 6'd12, 1, 6'd12, 8'h00, 64'hFFFFFFFFFFFFFFFF, 1, IV, IV);
    vecs[13] = mk(1, 6'd12, 0, 6'd0,  8'h00, 64'h0, 1, IV, IV);
    vecs[14] = mk(1, 6'd21, 1, 6'd20, 8'hFF, 64'h5555555555555555, 1, IV, IV);
    vecs[15] = mk(1, 6'd20, 0, 6'd0,  8'h00, 64'h0, 1, 64'h5555555555555555, 64'h5555555555555555);
    vecs[16] = mk(0, 6'd0,  0, 6'd21, 8'hFF, 64'h0, 0, 64'h5555555555555555, 64'h5555555555555555);
    vecs[17] = mk(1, 6'd21, 0, 6'd0,  8'h00, 64'h0, 1, IV, IV);

    // Reset state
    repeat (3) tick();
    chk("rst_valid", 64'(wf_valid), 64'd0);
    chk("rst_data", wf_data, 64'd0);
    chk("rst_busy", 64'(wf_busy), 64'd1);
    chk("rst_or_data", or_data, 64'd0);
    chk("rst_or_valid", 64'(or_valid), 64'd0);

    // Clear engine length
    reset_in = 1'b0;
    n = 0;
    while (wf_busy && n < 200) begin
      tick();
      n++;
    end
    chk("init_cycles", 64'(n), 64'd64);
    chk("init_rf_busy", 64'(rf_busy), 64'd0);
    chk("init_or_busy", 64'(or_busy), 64'd0);

    // Table: OUTPUT_REG=1 copy must trail the write-first copy by one cycle
    prev_valid = 1'b0;
    prev_data  = 64'h0;
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rd_en, vecs[i].rd_addr, vecs[i].wr_en, vecs[i].wr_addr,
            vecs[i].be, vecs[i].wdata);
      tick();
      chk($sformatf("v%0d_valid", i), 64'(wf_valid), 64'(vecs[i].exp_valid));
      chk($sformatf("v%0d_wf", i), wf_data, vecs[i].exp_wf);
      chk($sformatf("v%0d_rf_valid", i), 64'(rf_valid), 64'(vecs[i].exp_valid));
      chk($sformatf("v%0d_rf", i), rf_data, vecs[i].exp_rf);
      chk($sformatf("v%0d_or_valid", i), 64'(or_valid), 64'(prev_valid));
      chk($sformatf("v%0d_or", i), or_data, prev_data);
      prev_valid = vecs[i].exp_valid;
      prev_data  = vecs[i].exp_wf;
    end

    // Back-to-back reads through the output register
    drive(0, 6'd0, 1, 6'd1, 8'hFF, 64'h1111111111111111); tick();
    drive(0, 6'd0, 1, 6'd2, 8'hFF, 64'h2222222222222222); tick();
    drive(0, 6'd0, 1, 6'd3, 8'hFF, 64'h3333333333333333); tick();
    drive(1, 6'd1, 0, 6'd0, 8'h00, 64'h0); tick();
    chk("b2b_t1_or_valid", 64'(or_valid), 64'd0);
    chk("b2b_t1_wf", wf_data, 64'h1111111111111111);
    drive(1, 6'd2, 0, 6'd0, 8'h00, 64'h0); tick();
    chk("b2b_t2_or_valid", 64'(or_valid), 64'd1);
    chk("b2b_t2_or", or_data, 64'h1111111111111111);
    drive(1, 6'd3, 0, 6'd0, 8'h00, 64'h0); tick();
    chk("b2b_t3_or_valid", 64'(or_valid), 64'd1);
    chk("b2b_t3_or", or_data, 64'h2222222222222222);
    drive(0, 6'd0, 0, 6'd0, 8'h00, 64'h0); tick();
    chk("b2b_t4_or_valid", 64'(or_valid), 64'd1);
    chk("b2b_t4_or", or_data, 64'h3333333333333333);
    chk("b2b_t4_wf_valid", 64'(wf_valid), 64'd0);
    tick();
    chk("b2b_t5_or_valid", 64'(or_valid), 64'd0);
    chk("b2b_t5_or_hold", or_data, 64'h3333333333333333);

    // Reset mid-clear restarts the counter; requests during INIT are dropped
    reset_in = 1'b1; tick();
    reset_in = 1'b0;
    repeat (20) tick();
    chk("mid_busy20", 64'(wf_busy), 64'd1);
    reset_in = 1'b1; tick();
    chk("mid_rst_busy", 64'(wf_busy), 64'd1);
    reset_in = 1'b0;
    n = 0;
    while (wf_busy && n < 200) begin
      drive(n == 30, 6'd0, n == 40, 6'd7, 8'hFF, 64'h0000000000001234);
      tick();
      n++;
      if (n == 31) chk("init_read_dropped", 64'(wf_valid), 64'd0);
    end
    chk("restart_cycles", 64'(n), 64'd64);
    drive(1, 6'd7, 0, 6'd0, 8'h00, 64'h0); tick();
    chk("init_write_dropped_valid", 64'(wf_valid), 64'd1);
    chk("init_write_dropped", wf_data, IV);
    chk("init_write_dropped_rf", rf_data, IV);
    drive(0, 6'd0, 0, 6'd0, 8'h00, 64'h0); tick();
    chk("post_or_valid", 64'(or_valid), 64'd1);
    chk("post_or", or_data, IV);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
